// File: rtl/sparse_pkg.sv
// Shared constants and FSM state type for the row-wise sparse x dense sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: N (matrix dimension, even), PAIRS (=N/2 column pairs per dense row),
//           AW (row/column address width), PW (CSR non-zero index width),
//           ctrl_state_t (sequencer states).
package sparse_pkg;

  localparam int N     = 560;
  localparam int PAIRS = N / 2;
  localparam int AW    = 10;
  localparam int PW    = 16;

  typedef enum logic [3:0] {
    IDLE,
    RP_A,
    RP_B,
    RP_C,
    ZROW,
    NZ_A,
    NZ_B,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/rowwise_spmm_ctrl_if.sv
// Bundle of every sequencer-facing signal except clock and reset.
// Latency: n/a (wires only).
// Backpressure: out_ready gates new accumulator reads; valid is not stallable.
// Modports: master = sequencer side (drives addresses, enables, status);
//           slave  = memories / MAC datapath / consumer side.
interface rowwise_spmm_ctrl_if #(
  parameter int AW = sparse_pkg::AW,
  parameter int PW = sparse_pkg::PW
);

  // control / status
  logic          start;
  logic          busy;
  logic          done;
  // CSR row-pointer memory (sync read)
  logic [AW-1:0] rp_addr;
  logic [PW-1:0] rp_data;
  // CSR non-zero memory (sync read)
  logic [PW-1:0] nz_addr;
  logic [AW-1:0] nz_col;
  logic [31:0]   nz_val;
  // dense memory addressing
  logic [AW-1:0] addrext;
  logic [AW-2:0] bpair;
  // MAC datapath
  logic [31:0]   a_val;
  logic          mac_en;
  logic          mac_first;
  logic [AW-2:0] mac_pair;
  // accumulator drain
  logic          rd_en;
  logic [AW-2:0] rd_pair;
  logic          out_ready;
  logic          valid;
  logic          zeros;
  logic [AW-1:0] out_row;

  modport master (
    input  start, rp_data, nz_col, nz_val, out_ready,
    output busy, done, rp_addr, nz_addr, addrext, bpair, a_val,
           mac_en, mac_first, mac_pair, rd_en, rd_pair, valid, zeros, out_row
  );

  modport slave (
    output start, rp_data, nz_col, nz_val, out_ready,
    input  busy, done, rp_addr, nz_addr, addrext, bpair, a_val,
           mac_en, mac_first, mac_pair, rd_en, rd_pair, valid, zeros, out_row
  );

endinterface

// File: rtl/drain_ctrl.sv
// Accumulator drain: walks rd_pair 0..PAIRS-1 and produces valid/out_row.
// Latency: valid is rd_en delayed one cycle; zeros-row index is shown the same cycle.
// Backpressure: out_ready gates only new reads; the pipelined valid never stalls.
// Ports: active (FSM in DRAIN), zrow (FSM in ZROW), row (current row),
//        rd_en/rd_pair to the accumulator, last (final pair issued),
//        valid/out_row towards the consumer.
module drain_ctrl #(
  parameter int PAIRS = sparse_pkg::PAIRS,
  parameter int AW    = sparse_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active,
  input  logic          zrow,
  input  logic          out_ready,
  input  logic [AW-1:0] row,
  output logic          rd_en,
  output logic [AW-2:0] rd_pair,
  output logic          last,
  output logic          valid,
  output logic [AW-1:0] out_row
);

  localparam logic [AW-2:0] LAST_PAIR = (AW-1)'(PAIRS - 1);
  localparam logic [AW-2:0] ONE_PAIR  = (AW-1)'(1);

  logic [AW-2:0] cnt;
  logic [AW-1:0] row_q;

  assign rd_en   = active & out_ready;
  assign last    = rd_en && (cnt == LAST_PAIR);
  assign rd_pair = cnt;
  // An empty row is reported in the ZROW cycle itself; drained rows are
  // reported one cycle after the read, so the row index is registered.
  assign out_row = zrow ? row : row_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      valid <= 1'b0;
      row_q <= '0;
    end else begin
      valid <= rd_en;
      if (rd_en) begin
        cnt <= last ? '0 : cnt + ONE_PAIR;
      end
      if (rd_en || zrow) begin
        row_q <= row;
      end
    end
  end

endmodule

// File: rtl/rowwise_spmm_ctrl.sv
// Row-wise (Gustavson) SpMM sequencer: walks CSR rows, streams dense rows to a 2-lane MAC, drains results.
// Latency: mac_* trail the STREAM cycle by one (dense read); valid trails rd_en by one (accumulator read).
// Backpressure: out_ready low holds the drain (FSM waits in DRAIN); streaming itself never stalls.
// Ports: clk, rst (async, active high); bus (master modport) carries start/busy/done,
//        CSR and dense memory addressing, MAC enables, and the drain handshake.
module rowwise_spmm_ctrl #(
  parameter int N  = sparse_pkg::N,
  parameter int AW = sparse_pkg::AW,
  parameter int PW = sparse_pkg::PW
) (
  input  logic                clk,
  input  logic                rst,
  rowwise_spmm_ctrl_if.master bus
);

  import sparse_pkg::*;

  localparam logic [AW-2:0] LAST_PAIR = (AW-1)'(N/2 - 1);
  localparam logic [AW-2:0] ONE_PAIR  = (AW-1)'(1);
  localparam logic [AW-1:0] LAST_ROW  = AW'(N - 1);
  localparam logic [AW-1:0] ONE_ROW   = AW'(1);
  localparam logic [PW-1:0] ONE_PTR   = PW'(1);

  ctrl_state_t   state, state_nxt;
  logic [AW-1:0] row;
  logic [AW-1:0] col;
  logic [PW-1:0] ptr;
  logic [PW-1:0] endp;
  logic [PW-1:0] first;
  logic [AW-2:0] bpair_q;
  logic [31:0]   a_val_q;
  logic          mac_en_q;
  logic          mac_first_q;
  logic [AW-2:0] mac_pair_q;

  logic          in_stream;
  logic          stream_last;
  logic          drain_last;
  logic          row_end;

  assign in_stream   = (state == STREAM);
  assign stream_last = in_stream && (bpair_q == LAST_PAIR);
  assign row_end     = (state == ZROW) || ((state == DRAIN) && drain_last);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start) state_nxt = RP_A;
      RP_A:   state_nxt = RP_B;
      RP_B:   state_nxt = RP_C;
      // rp_data now holds the end pointer; compare before it is registered.
      RP_C:   state_nxt = (bus.rp_data == ptr) ? ZROW : NZ_A;
      ZROW:   state_nxt = (row == LAST_ROW) ? DONE : RP_A;
      NZ_A:   state_nxt = NZ_B;
      NZ_B:   state_nxt = STREAM;
      STREAM: if (stream_last) state_nxt = ((ptr + ONE_PTR) == endp) ? DRAIN : NZ_A;
      DRAIN:  if (drain_last) state_nxt = (row == LAST_ROW) ? DONE : RP_A;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      ptr         <= '0;
      endp        <= '0;
      first       <= '0;
      bpair_q     <= '0;
      a_val_q     <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      mac_pair_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.start) row <= '0;
        RP_B: ptr <= bus.rp_data;
        RP_C: begin
          endp  <= bus.rp_data;
          first <= ptr;
        end
        NZ_B: begin
          a_val_q <= bus.nz_val;
          col     <= bus.nz_col;
          bpair_q <= '0;
        end
        STREAM: begin
          bpair_q <= stream_last ? '0 : bpair_q + ONE_PAIR;
          if (stream_last) ptr <= ptr + ONE_PTR;
        end
        default: ;
      endcase
      if (row_end && (row != LAST_ROW)) begin
        row <= row + ONE_ROW;
      end
      // Dense data arrives one cycle after its address: align MAC controls.
      mac_en_q    <= in_stream;
      mac_pair_q  <= in_stream ? bpair_q : '0;
      mac_first_q <= in_stream && (ptr == first);
    end
  end

  drain_ctrl #(
    .PAIRS (N / 2),
    .AW    (AW)
  ) u_drain (
    .clk       (clk),
    .rst       (rst),
    .active    (state == DRAIN),
    .zrow      (state == ZROW),
    .out_ready (bus.out_ready),
    .row       (row),
    .rd_en     (bus.rd_en),
    .rd_pair   (bus.rd_pair),
    .last      (drain_last),
    .valid     (bus.valid),
    .out_row   (bus.out_row)
  );

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.zeros     = (state == ZROW);
  assign bus.rp_addr   = (state == RP_A) ? row :
                         (state == RP_B) ? row + ONE_ROW : '0;
  assign bus.nz_addr   = (state == NZ_A) ? ptr : '0;
  assign bus.addrext   = in_stream ? col : '0;
  assign bus.bpair     = in_stream ? bpair_q : '0;
  assign bus.a_val     = a_val_q;
  assign bus.mac_en    = mac_en_q;
  assign bus.mac_first = mac_first_q;
  assign bus.mac_pair  = mac_pair_q;

endmodule

// File: tb/tb_rowwise_spmm_ctrl.sv
// Scoreboard bench for rowwise_spmm_ctrl at N=8.
// Expected MAC and output events are derived from the CSR contents by a row/non-zero loop model.
// A negedge monitor pops and compares whenever the DUT raises mac_en, valid, zeros or done.
module tb_rowwise_spmm_ctrl;

  localparam int N  = 8;
  localparam int AW = 10;
  localparam int PW = 16;
  localparam int NP = N / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rowwise_spmm_ctrl_if #(.AW(AW), .PW(PW)) bus();

  rowwise_spmm_ctrl #(.N(N), .AW(AW), .PW(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memories (sync read, one cycle) ----------------
  logic [PW-1:0] rp_mem  [0:15];
  logic [AW-1:0] col_mem [0:63];
  logic [31:0]   val_mem [0:63];

  always @(posedge clk) begin
    bus.rp_data <= rp_mem[bus.rp_addr[3:0]];
    bus.nz_col  <= col_mem[bus.nz_addr[5:0]];
    bus.nz_val  <= val_mem[bus.nz_addr[5:0]];
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [AW-1:0] col;
    logic [31:0]   val;
    logic [AW-2:0] pair;
    logic          first;
  } mac_t;

  typedef struct packed {
    logic [AW-1:0] row;
    logic [AW-2:0] pair;
    logic          zero;
  } out_t;

  mac_t mac_q[$];
  out_t out_q[$];
  mac_t me;
  out_t oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int exp_lat = -1;
  bit expect_done = 1'b0;
  int ready_mode = 0;

  logic          prev_rd_en;
  logic [AW-2:0] prev_rd_pair;
  logic [AW-1:0] prev_addrext;
  logic [AW-2:0] prev_bpair;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // ---------------- reference model ----------------
  // Every non-zero of a row streams NP pairs (first burst overwrites), then the
  // row drains NP pairs; an empty row gives a single zeros event.
  task automatic build_model(output int lat);
    int b;
    int e;
    lat = 1;
    for (int r = 0; r < N; r++) begin
      b = int'(rp_mem[r]);
      e = int'(rp_mem[r+1]);
      if (b == e) begin
        out_q.push_back('{row: AW'(r), pair: '0, zero: 1'b1});
        lat += 4;
      end else begin
        for (int p = b; p < e; p++)
          for (int j = 0; j < NP; j++)
            mac_q.push_back('{col: col_mem[p], val: val_mem[p], pair: (AW-1)'(j), first: (p == b)});
        for (int j = 0; j < NP; j++)
          out_q.push_back('{row: AW'(r), pair: (AW-1)'(j), zero: 1'b0});
        lat += 3 + (e - b) * (2 + NP) + NP;
      end
    end
  endtask

  // ---------------- matrices ----------------
  task automatic load_plan();
    // row0 {5:3}, row1 empty, row2 {2:10,7:20}, row3 empty, row4 {1:4},
    // row5 empty, row6 {0:5}, row7 {6:6}
    rp_mem[0] = 0; rp_mem[1] = 1; rp_mem[2] = 1; rp_mem[3] = 3; rp_mem[4] = 3;
    rp_mem[5] = 4; rp_mem[6] = 4; rp_mem[7] = 5; rp_mem[8] = 6;
    col_mem[0] = 5; val_mem[0] = 3;
    col_mem[1] = 2; val_mem[1] = 10;
    col_mem[2] = 7; val_mem[2] = 20;
    col_mem[3] = 1; val_mem[3] = 4;
    col_mem[4] = 0; val_mem[4] = 5;
    col_mem[5] = 6; val_mem[5] = 6;
  endtask

  task automatic load_empty();
    for (int r = 0; r <= N; r++) rp_mem[r] = '0;
  endtask

  task automatic load_random();
    int p;
    int nnz;
    p = 0;
    for (int r = 0; r < N; r++) begin
      rp_mem[r] = PW'(p);
      nnz = ($urandom_range(0, 9) < 3) ? 0 : int'($urandom_range(1, 3));
      for (int k = 0; k < nnz; k++) begin
        col_mem[p] = AW'($urandom_range(0, N - 1));
        val_mem[p] = $urandom;
        p++;
      end
    end
    rp_mem[N] = PW'(p);
  endtask

  // ---------------- out_ready driver (changes just after the active edge) ----------------
  initial begin
    int ph;
    ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      prev_rd_en   = 1'b0;
      prev_rd_pair = '0;
      prev_addrext = '0;
      prev_bpair   = '0;
    end else begin
      if (bus.mac_en) begin
        if (mac_q.size() == 0) begin
          fail_now("mac_en", "asserted with no MAC expected");
        end else begin
          me = mac_q.pop_front();
          chk("mac_pair", 64'(bus.mac_pair), 64'(me.pair));
          chk("mac_first", 64'(bus.mac_first), 64'(me.first));
          chk("a_val", 64'(bus.a_val), 64'(me.val));
          chk("addrext", 64'(prev_addrext), 64'(me.col));
          chk("bpair", 64'(prev_bpair), 64'(me.pair));
        end
      end
      if (bus.valid || bus.zeros) begin
        if (out_q.size() == 0) begin
          fail_now("out_event", "valid/zeros asserted with no output expected");
        end else begin
          oe = out_q.pop_front();
          chk("out_row", 64'(bus.out_row), 64'(oe.row));
          chk("zeros", 64'(bus.zeros), 64'(oe.zero));
          chk("valid", 64'(bus.valid), 64'(!oe.zero));
          if (!oe.zero) chk("rd_pair", 64'(prev_rd_pair), 64'(oe.pair));
        end
      end
      if (prev_rd_en || bus.valid) chk("valid_follows_rd_en", 64'(bus.valid), 64'(prev_rd_en));
      if (bus.rd_en) chk("rd_en_needs_ready", 64'(bus.out_ready), 64'd1);
      if (bus.done) begin
        if (!expect_done) begin
          fail_now("done", "pulse with no job outstanding");
        end else begin
          chk("mac_q_empty", 64'(mac_q.size()), 64'd0);
          chk("out_q_empty", 64'(out_q.size()), 64'd0);
          if (exp_lat >= 0) chk("job_cycles", 64'(cyc - start_cyc + 1), 64'(exp_lat));
          expect_done = 1'b0;
        end
      end
      prev_rd_en   = bus.rd_en;
      prev_rd_pair = bus.rd_pair;
      prev_addrext = bus.addrext;
      prev_bpair   = bus.bpair;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 64'({bus.rp_addr, bus.nz_addr, bus.addrext, bus.bpair, bus.out_row}), 64'd0);
    chk({tag, "_flags"}, 64'({bus.busy, bus.done, bus.mac_en, bus.mac_first, bus.rd_en,
                              bus.valid, bus.zeros, bus.mac_pair, bus.rd_pair}), 64'd0);
    chk({tag, "_a_val"}, 64'(bus.a_val), 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2 rst = 1'b1;
    mac_q.delete();
    out_q.delete();
    expect_done = 1'b0;
    exp_lat = -1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic start_job(input int mode, input bit chk_lat);
    int lat;
    build_model(lat);
    exp_lat = chk_lat ? lat : -1;
    ready_mode = mode;
    expect_done = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 start_cyc = cyc;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (expect_done && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expect_done) begin
      fail_now("job_timeout", "done not seen within 5000 cycles");
      reset_dut();
    end else begin
      @(negedge clk);
      #1 chk("idle_after_done", 64'(bus.busy), 64'd0);
    end
  endtask

  task automatic run_job(input int mode, input bit dup_start, input bit chk_lat);
    start_job(mode, chk_lat);
    if (dup_start) begin
      repeat (15) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_done();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int m;
    rst = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) rp_mem[i] = '0;
    for (int i = 0; i < 64; i++) begin
      col_mem[i] = '0;
      val_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    #1 rst = 1'b0;

    // directed matrix, always ready, with cycle-count check
    load_plan();
    run_job(0, 1'b0, 1'b1);

    // same matrix, out_ready 1,0,0 pattern, stray start while busy
    load_plan();
    run_job(1, 1'b1, 1'b0);

    // all rows empty: N zeros pulses, 1+4N cycles
    load_empty();
    run_job(0, 1'b0, 1'b1);

    // reset asserted in STREAM, then a full rerun from row 0
    load_plan();
    start_job(0, 1'b0);
    n = 0;
    while (!bus.mac_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mac_en) fail_now("stream_wait", "no mac_en within 200 cycles");
    chk("addrext_in_stream", 64'(bus.addrext), 64'd5);
    #2 rst = 1'b1;
    #1 check_zero("rst_stream");
    mac_q.delete();
    out_q.delete();
    expect_done = 1'b0;
    exp_lat = -1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("idle_after_abort", 64'(bus.busy), 64'd0);
    load_plan();
    run_job(0, 1'b0, 1'b1);

    // randomized matrices and out_ready behaviour
    for (int t = 0; t < 8; t++) begin
      load_random();
      m = int'($urandom_range(0, 2));
      run_job(m, 1'b0, m == 0);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rowwise_spmm_ctrl.md
# rowwise_spmm_ctrl

Sequencer for the row-wise (Gustavson) sparse × dense multiplier. It walks a CSR-encoded sparse matrix row by row and, for every non-zero `a[i][k]`, streams dense row `k` two elements per cycle into a 2-lane MAC/accumulator datapath. It then drains the accumulated output row two elements per cycle as `valid`, and flags empty rows with `zeros`. It sits between the CSR/dense memories and the MAC row buffer, and owns all addressing and enables.

## Interface
Parameters:
- `N`, 560: matrix dimension; must be even.
- `AW`, 10: row/column address width; N+1 must fit.
- `PW`, 16: CSR non-zero index width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; ignored unless IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after last row.
- `rp_addr`  out  AW  CSR row-pointer address; sync read, data next cycle.
- `rp_data`  in  PW  row-pointer word.
- `nz_addr`  out  PW  non-zero index; sync read, data next cycle.
- `nz_col`  in  AW  column of non-zero.
- `nz_val`  in  32  value of non-zero.
- `addrext`  out  AW  dense row address (= nz_col).
- `bpair`  out  AW-1  dense column-pair index; elements 2·bpair, 2·bpair+1.
- `a_val`  out  32  registered current non-zero value.
- `mac_en`  out  1  accumulate enable, aligned with dense data arrival.
- `mac_first`  out  1  with mac_en: overwrite instead of accumulate.
- `mac_pair`  out  AW-1  accumulator pair being written.
- `rd_en`  out  1  accumulator read enable.
- `rd_pair`  out  AW-1  accumulator pair read.
- `out_ready`  in  1  consumer can take a pair next cycle.
- `valid`  out  1  `dataout1/2` from datapath valid this cycle.
- `zeros`  out  1  one-cycle pulse: row `out_row` is all-zero.
- `out_row`  out  AW  row index for `valid`/`zeros`.

## Operation
- States: IDLE, RP_A, RP_B, RP_C, ZROW, NZ_A, NZ_B, STREAM, DRAIN, DONE.
- IDLE --start--> RP_A with row=0.
- RP_A: rp_addr=row. RP_B: rp_addr=row+1, ptr<=rp_data. RP_C: endp<=rp_data, first<=ptr.
- RP_C -> ZROW if ptr==endp, else NZ_A.
- ZROW: zeros=1, out_row=row, then next-row.
- NZ_A: nz_addr=ptr. NZ_B: a_val<=nz_val, col<=nz_col -> STREAM with bpair=0.
- STREAM: addrext=col; bpair counts 0..N/2-1, one per cycle.
  - After N/2-1: ptr++.
  - -> DRAIN if ptr+1==endp, else NZ_A.
- DRAIN: rd_en=out_ready, rd_pair advances only when rd_en.
  - After rd_pair=N/2-1 is issued: next-row.
- next-row: if row==N-1 -> DONE, else row++, -> RP_A.
- DONE: done=1 one cycle -> IDLE.
- Counters are unsigned and never wrap in legal use. rp_data values are trusted (endp≥ptr).

## Timing
- Reset (async assert, sync deassert): state IDLE, all outputs 0, counters 0.
- Dense memory latency 1: mac_en/mac_pair/mac_first are STREAM/bpair/(ptr==first) delayed one register.
- The last mac_en of a row lands in the first NZ_A or DRAIN cycle. Datapath tolerates read and write of different pairs in one cycle.
- Accumulator read latency 1: valid = rd_en delayed one cycle, out_row held.
- valid is non-stallable; out_ready gates only new reads.
- Non-empty row cost: 3 + nnz·(2+N/2) + N/2 cycles (out_ready=1).
- Empty row cost: 4 cycles.
- start while busy: no effect. rst mid-row: abort to IDLE immediately; no done.
- out_ready low for the whole DRAIN: FSM stays in DRAIN indefinitely.

## Structure
- `sparse_pkg`: `N`, `PAIRS=N/2`, `AW`, `PW`, state enum `ctrl_state_t`.
- One sub-module `drain_ctrl`: rd_pair counter, rd_en gating, valid/out_row delay stage.
- Top module holds the FSM and the STREAM/MAC alignment registers.

## Test plan
- N=8, rp={0,1,1,3,…}: row0 one nz (col 5, val 3) -> 4 mac_en, first cycle mac_first=1, addrext=5, then 4 valid, out_row=0.
- Same matrix: row1 empty -> single zeros pulse with out_row=1, no valid, no mac_en.
- Row2 nz cols {2,7} -> two STREAM bursts; mac_first only on the first burst's pairs; 8 mac_en total.
- out_ready toggling 1,0,0,1,… in DRAIN -> rd_pair never skips. Each valid arrives one cycle after a cycle with rd_en=1. Exactly N/2 valids.
- All rows empty -> N zeros pulses with out_row 0..N-1, then done; total 1+4N cycles after start.
- rst asserted in STREAM -> outputs 0 the same cycle. A subsequent start reprocesses from row 0.
